// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the sequential 8x8 multiplier:
//   - mul_state_e : controller states (MUL_IDLE, MUL_RUN, MUL_DONE)
//   - MUL_STEPS   : number of nibble-pair steps per product
//   - MUL_NIB     : nibble width fed to the 4x4 array
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam int MUL_STEPS = 4;
    localparam int MUL_NIB   = 4;

endpackage

// File: rtl/mul8x8_seq_if.sv
// mul8x8_seq_if
// Request/result bundle between the ALU operand registers and the multiplier.
//   start : request a multiply (master -> slave)
//   a, b  : 8-bit unsigned operands, sampled when the request is accepted
//   busy  : multiply in progress
//   done  : one-cycle pulse, res valid from this cycle on
//   res   : 16-bit product, held until the next done
//   state : controller state, exported for observation
//
// Handshake: start acts as "valid" and !busy acts as "ready". A request is
// accepted on a rising edge where start=1 and busy=0; a and b are captured
// on that same edge and may change freely afterwards. start while busy=1 is
// dropped without any indication. Each accepted request produces exactly one
// done pulse unless reset intervenes.
interface mul8x8_seq_if;
    import mul_pkg::*;

    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] res;
    mul_state_e  state;

    modport master (
        output start, a, b,
        input  busy, done, res, state
    );

    modport slave (
        input  start, a, b,
        output busy, done, res, state
    );
endinterface

// File: rtl/fadder.sv
// fadder
// Parameterised adder/subtractor.
//   a, b       : WIDTH-bit operands
//   sub_enable : 1 computes a - b (b inverted, caller supplies carry_in=1)
//   carry_in   : carry into bit 0
//   sum        : WIDTH-bit result
//   carry_out  : carry out of the top bit
module fadder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_enable,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    logic [WIDTH-1:0] b_eff;

    assign b_eff = sub_enable ? ~b : b;
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
endmodule

// File: rtl/mul4x4.sv
// mul4x4
// Combinational 4x4 unsigned nibble multiplier.
//   a, b : 4-bit unsigned operands
//   p    : 8-bit product
module mul4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'h0, a} * {4'h0, b};
endmodule

// File: rtl/mul8x8_seq.sv
// mul8x8_seq
// Sequential 8x8 unsigned multiplier built on a single 4x4 array. One nibble
// pair is multiplied per cycle and the shifted partial products are summed
// into a 16-bit accumulator; the fourth step writes the result directly.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mul8x8_seq_if slave (start/a/b in; busy/done/res/state out)
module mul8x8_seq
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mul8x8_seq_if.slave bus
);
    mul_state_e           state_q;
    logic [1:0]           step_q;
    logic [7:0]           ra_q;
    logic [7:0]           rb_q;
    logic [15:0]          acc_q;
    logic [15:0]          res_q;
    logic                 busy_q;
    logic                 done_q;

    logic [MUL_NIB-1:0]   a_nib;
    logic [MUL_NIB-1:0]   b_nib;
    logic [7:0]           p;
    logic [15:0]          p_shifted;
    logic [15:0]          acc_d;
    logic                 carry_unused;

    // step[0] picks the a half, step[1] the b half. The weight of a partial
    // product is 4 * (number of high nibbles involved).
    always_comb begin
        a_nib = step_q[0] ? ra_q[2*MUL_NIB-1:MUL_NIB] : ra_q[MUL_NIB-1:0];
        b_nib = step_q[1] ? rb_q[2*MUL_NIB-1:MUL_NIB] : rb_q[MUL_NIB-1:0];
        case (step_q)
            2'd0:    p_shifted = {8'h00, p};
            2'd3:    p_shifted = {p, 8'h00};
            default: p_shifted = {4'h0, p, 4'h0};
        endcase
    end

    mul4x4 u_mul4x4 (
        .a (a_nib),
        .b (b_nib),
        .p (p)
    );

    // 0xFF*0xFF fits in 16 bits, so the carry out is never set.
    fadder #(.WIDTH(16)) u_acc_add (
        .a          (acc_q),
        .b          (p_shifted),
        .sub_enable (1'b0),
        .carry_in   (1'b0),
        .sum        (acc_d),
        .carry_out  (carry_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            step_q  <= 2'd0;
            ra_q    <= 8'h00;
            rb_q    <= 8'h00;
            acc_q   <= 16'h0000;
            res_q   <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE, MUL_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        ra_q    <= bus.a;
                        rb_q    <= bus.b;
                        acc_q   <= 16'h0000;
                        step_q  <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= MUL_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= MUL_IDLE;
                    end
                end
                MUL_RUN: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'(MUL_STEPS - 1)) begin
                        // Last step bypasses acc so res lands on this edge.
                        res_q   <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= MUL_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= MUL_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.res   = res_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_mul8x8_seq.sv
// tb_mul8x8_seq
// Self-checking bench for mul8x8_seq: directed scenarios plus randomized
// operands scored against an arithmetic reference product.
module tb_mul8x8_seq;
    import mul_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [15:0] exp_q[$];

    mul8x8_seq_if bus ();

    mul8x8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int prod;
        prod = int'(x) * int'(y);
        return prod[15:0];
    endfunction

    // ---------------- driver ----------------
    // Issues one request from an idle DUT and waits (bounded) for done.
    // lat counts edges from acceptance to the sampled done cycle.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] r, output int lat, output int busy_cnt);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom_range(0, 255));
        bus.b     = 8'($urandom_range(0, 255));
        lat       = 1;
        busy_cnt  = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        r = bus.res;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        tests_run++;
        if (bus.res !== 16'h0000) begin tests_failed++; $display("FAIL reset_res got=%h exp=0000", bus.res); end
        tests_run++;
        if (bus.state !== MUL_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, MUL_IDLE); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] r;
        logic [15:0] held;
        int lat, bc;
        run_op(8'h12, 8'h34, r, lat, bc);
        tests_run++;
        if (r !== 16'h03A8) begin tests_failed++; $display("FAIL basic_res got=%h exp=03a8", r); end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        tests_run++;
        if (bc !== 4) begin tests_failed++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
        held = r;
        @(posedge clk); #1;
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
        tests_run++;
        if (bus.res !== held) begin tests_failed++; $display("FAIL basic_res_held got=%h exp=%h", bus.res, held); end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [15:0] r;
        int lat, bc;
        va = '{8'hFF, 8'h00, 8'h01};
        vb = '{8'hFF, 8'hA7, 8'hA7};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], r, lat, bc);
            tests_run++;
            if (r !== ref_mul(va[i], vb[i])) begin
                tests_failed++;
                $display("FAIL vector_res a=%h b=%h got=%h exp=%h", va[i], vb[i], r, ref_mul(va[i], vb[i]));
            end
            tests_run++;
            if (lat !== 5) begin tests_failed++; $display("FAIL vector_latency a=%h got=%0d exp=5", va[i], lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_in_mul();
        int dones, first_done;
        logic [15:0] got;
        dones = 0; first_done = -1; got = 16'hxxxx;
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h10;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            if (bus.done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = c;
                got = bus.res;
            end
            if (c == 2) begin
                bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h05;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (dones !== 1) begin tests_failed++; $display("FAIL ignore_start_done_count got=%0d exp=1", dones); end
        tests_run++;
        if (first_done !== 5) begin tests_failed++; $display("FAIL ignore_start_latency got=%0d exp=5", first_done); end
        tests_run++;
        if (got !== ref_mul(8'h10, 8'h10)) begin tests_failed++; $display("FAIL ignore_start_res got=%h exp=0100", got); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_start_idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        logic [15:0] rq[$];
        logic [15:0] mid_res;
        int d0, d1;
        logic [15:0] r0, r1;
        mid_res = 16'hxxxx;
        bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'hF0;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            if (bus.done === 1'b1) begin
                dq.push_back(c);
                rq.push_back(bus.res);
            end
            if (c == 7) mid_res = bus.res;
            if (c == 5) begin bus.a = 8'h80; bus.b = 8'h02; end
            if (c == 10) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        d0 = (dq.size() > 0) ? dq[0] : -1;
        d1 = (dq.size() > 1) ? dq[1] : -1;
        r0 = (rq.size() > 0) ? rq[0] : 16'hxxxx;
        r1 = (rq.size() > 1) ? rq[1] : 16'hxxxx;
        tests_run++;
        if (dq.size() !== 2) begin tests_failed++; $display("FAIL b2b_done_count got=%0d exp=2", dq.size()); end
        tests_run++;
        if (d0 !== 5) begin tests_failed++; $display("FAIL b2b_first_done got=%0d exp=5", d0); end
        tests_run++;
        if (d1 !== 10) begin tests_failed++; $display("FAIL b2b_second_done got=%0d exp=10", d1); end
        tests_run++;
        if (r0 !== ref_mul(8'h0F, 8'hF0)) begin tests_failed++; $display("FAIL b2b_first_res got=%h exp=0e10", r0); end
        tests_run++;
        if (r1 !== ref_mul(8'h80, 8'h02)) begin tests_failed++; $display("FAIL b2b_second_res got=%h exp=0100", r1); end
        tests_run++;
        if (mid_res !== ref_mul(8'h0F, 8'hF0)) begin tests_failed++; $display("FAIL b2b_res_held got=%h exp=0e10", mid_res); end
    endtask

    task automatic test_reset_abort();
        int dones;
        logic [15:0] r;
        int lat, bc;
        bus.start = 1'b1; bus.a = 8'hAB; bus.b = 8'hCD;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (bus.res !== 16'h0000) begin tests_failed++; $display("FAIL abort_res got=%h exp=0000", bus.res); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        run_op(8'hAB, 8'hCD, r, lat, bc);
        tests_run++;
        if (r !== 16'h88EF) begin tests_failed++; $display("FAIL abort_restart_res got=%h exp=88ef", r); end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL abort_restart_latency got=%0d exp=5", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic [15:0] r, e;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_mul(x, y));
            run_op(x, y, r, lat, bc);
            e = exp_q.pop_front();
            tests_run++;
            if (r !== e || lat !== 5) begin
                tests_failed++;
                $display("FAIL random_op a=%h b=%h got=%h lat=%0d exp=%h lat=5", x, y, r, lat, e);
            end
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL random_queue_left got=%0d exp=0", exp_q.size()); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_start_in_mul();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
